// File: rtl/if_id_pkg.sv
// Shared types and constants for the IF/ID pipeline register.
// Optional performance counters are enabled with the IF_ID_PERF_EN macro
// (see if_id_register.sv).
package if_id_pkg;

  localparam int DATA_W  = 16;
  localparam int OPC_W   = 4;
  localparam int FIELD_W = 4;
  localparam int CNT_W   = 16;

  // Instruction field positions (MSB of each 4-bit field)
  localparam int OPC_HI = 15;
  localparam int RS_HI  = 11;
  localparam int RT_HI  = 7;
  localparam int LOW_HI = 3;

  localparam logic [DATA_W-1:0] NOP_INSTR = 16'h0000;

  typedef struct packed {
    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] instr;
  } if_id_entry_t;

  localparam if_id_entry_t ENTRY_ZERO = '{pc4: '0, instr: NOP_INSTR};

  // Occupancy encoded as {skid_valid, main_valid}
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } fill_state_t;

endpackage

// File: rtl/if_id_slot.sv
// One valid+entry storage slot. Priority: reset > clear > load > hold.
// Clear drops only the valid bit; the payload is zeroed by reset alone.
module if_id_slot
  import if_id_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  if_id_entry_t din,
  output logic         valid,
  output if_id_entry_t entry
);

  // Slot register: valid flag and payload
  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= 1'b0;
      entry <= ENTRY_ZERO;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      entry <= din;
    end
  end

endmodule

// File: rtl/if_id_register.sv
// IF/ID pipeline register with a 2-entry skid buffer.
// The main slot drives the decode-side outputs; the skid slot catches the
// one extra word IF may push while decode stalls, so in_ready is simply the
// registered complement of skid_valid.
// Define IF_ID_PERF_EN to add stall/bubble/flush counters.
//
//   state | meaning
//   EMPTY | no entry held, in_ready = 1
//   ONE   | main holds an entry, skid empty, in_ready = 1
//   FULL  | main and skid both hold entries, in_ready = 0
module if_id_register
  import if_id_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pc4,
  input  logic [DATA_W-1:0] in_instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pc4,
  output logic [DATA_W-1:0] out_instr,
  output logic [OPC_W-1:0]  out_opcode,
  output logic [3:0]        out_rs,
  output logic [3:0]        out_rt,
  output logic [3:0]        out_low
`ifdef IF_ID_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  logic         main_valid, skid_valid;
  if_id_entry_t main_entry, skid_entry;
  if_id_entry_t in_entry, main_din;
  logic         main_load, main_clear, main_sel_skid;
  logic         skid_load, skid_clear;
  logic         accept, drain;
  fill_state_t  fill;

  assign in_entry = '{pc4: in_pc4, instr: in_instr};
  assign fill     = fill_state_t'({skid_valid, main_valid});
  assign accept   = in_valid & in_ready & ~flush;
  assign drain    = main_valid & out_ready;

  // Slot control: flush wins, otherwise move data according to occupancy
  always_comb begin
    main_load     = 1'b0;
    main_clear    = 1'b0;
    main_sel_skid = 1'b0;
    skid_load     = 1'b0;
    skid_clear    = 1'b0;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (fill)
        EMPTY: begin
          if (accept) main_load = 1'b1;
        end
        ONE: begin
          if (drain) begin
            if (accept) main_load  = 1'b1;
            else        main_clear = 1'b1;
          end else if (accept) begin
            skid_load = 1'b1;
          end
        end
        FULL: begin
          if (drain) begin
            main_load     = 1'b1;
            main_sel_skid = 1'b1;
            skid_clear    = 1'b1;
          end
        end
        default: begin
          // skid valid without main cannot occur; recover to empty
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  assign main_din = main_sel_skid ? skid_entry : in_entry;

  if_id_slot u_main (
    .clock (clock),
    .reset (reset),
    .clear (main_clear),
    .load  (main_load),
    .din   (main_din),
    .valid (main_valid),
    .entry (main_entry)
  );

  if_id_slot u_skid (
    .clock (clock),
    .reset (reset),
    .clear (skid_clear),
    .load  (skid_load),
    .din   (in_entry),
    .valid (skid_valid),
    .entry (skid_entry)
  );

  assign in_ready   = ~skid_valid;
  assign out_valid  = main_valid;
  assign out_pc4    = main_entry.pc4;
  assign out_instr  = main_entry.instr;
  assign out_opcode = main_entry.instr[OPC_HI -: OPC_W];
  assign out_rs     = main_entry.instr[RS_HI  -: FIELD_W];
  assign out_rt     = main_entry.instr[RT_HI  -: FIELD_W];
  assign out_low    = main_entry.instr[LOW_HI -: FIELD_W];

`ifdef IF_ID_PERF_EN
  // Free-running wrap-around event counters, cleared only by reset
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (main_valid & ~out_ready) stall_cnt  <= stall_cnt + 1'b1;
      if (~main_valid)             bubble_cnt <= bubble_cnt + 1'b1;
      if (flush)                   flush_cnt  <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_register.sv
// Self-checking bench for if_id_register: queue-based reference model
// compared every cycle, plus directed literal expectations.
module tb_if_id_register;

  logic        clock = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [15:0] in_pc4, in_instr, out_pc4, out_instr;
  logic [3:0]  out_opcode, out_rs, out_rt, out_low;
`ifdef IF_ID_PERF_EN
  logic [15:0] stall_cnt, bubble_cnt, flush_cnt;
`endif

  if_id_register dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pc4     (in_pc4),
    .in_instr   (in_instr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc4    (out_pc4),
    .out_instr  (out_instr),
    .out_opcode (out_opcode),
    .out_rs     (out_rs),
    .out_rt     (out_rt),
    .out_low    (out_low)
`ifdef IF_ID_PERF_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: an ordered queue holding at most two words
  typedef struct packed {
    logic [15:0] pc4;
    logic [15:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] m_pc4 = '0, m_instr = '0;
  logic [15:0] m_stall = '0, m_bubble = '0, m_flush = '0;
  bit          started = 0;

  always @(posedge clock) begin
    bit ready_pre;
    started = 1;
    if (reset) begin
      m_stall = '0; m_bubble = '0; m_flush = '0;
    end else begin
      if (mq.size() > 0 && !out_ready) m_stall++;
      if (mq.size() == 0) m_bubble++;
      if (flush) m_flush++;
    end
    ready_pre = (mq.size() < 2);
    if (reset) begin
      mq.delete();
      m_pc4 = '0;
      m_instr = '0;
    end else if (flush) begin
      mq.delete();
    end else begin
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (in_valid && ready_pre) mq.push_back('{pc4: in_pc4, instr: in_instr});
    end
    if (mq.size() > 0) begin
      m_pc4 = mq[0].pc4;
      m_instr = mq[0].instr;
    end
  end

  // Log of instructions handed to decode (handshake completes on next edge)
  logic [15:0] log_q[$];

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clock) begin
    if (started) begin
      check("out_valid", out_valid, mq.size() > 0);
      check("in_ready", in_ready, mq.size() < 2);
      check("out_pc4", out_pc4, m_pc4);
      check("out_instr", out_instr, m_instr);
      check("out_opcode", out_opcode, m_instr[15:12]);
      check("out_rs", out_rs, m_instr[11:8]);
      check("out_rt", out_rt, m_instr[7:4]);
      check("out_low", out_low, m_instr[3:0]);
`ifdef IF_ID_PERF_EN
      check("stall_cnt", stall_cnt, m_stall);
      check("bubble_cnt", bubble_cnt, m_bubble);
      check("flush_cnt", flush_cnt, m_flush);
`endif
      if (out_valid === 1'b1 && out_ready && !flush && !reset) log_q.push_back(out_instr);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic offer(input logic [15:0] pc4, input logic [15:0] instr);
    in_valid = 1'b1;
    in_pc4   = pc4;
    in_instr = instr;
  endtask

  function automatic logic [15:0] log_at(input int i);
    if (i < log_q.size()) return log_q[i];
    return 16'hxxxx;
  endfunction

  initial begin
    bit accepted;
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    offer(16'h0100, 16'h1234);
    step(); step();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_in_ready", in_ready, 1);
    reset = 1'b0;
    step();
    check("rst_first_valid", out_valid, 1);
    check("rst_first_instr", out_instr, 16'h1234);
    in_valid = 1'b0; out_ready = 1'b1;
    step();

    // Streaming with no back-pressure
    log_q.delete();
    offer(16'h0002, 16'hA123);
    step();
    check("stream_instr0", out_instr, 16'hA123);
    check("stream_pc4_0", out_pc4, 16'h0002);
    check("stream_opcode", out_opcode, 4'hA);
    check("stream_rs", out_rs, 4'h1);
    check("stream_rt", out_rt, 4'h2);
    check("stream_low", out_low, 4'h3);
    offer(16'h0004, 16'hB456);
    step();
    check("stream_instr1", out_instr, 16'hB456);
    offer(16'h0006, 16'hC789);
    step();
    check("stream_instr2", out_instr, 16'hC789);
    check("stream_in_ready", in_ready, 1);
    in_valid = 1'b0;
    step(); step();
    check("stream_log_n", log_q.size(), 3);
    check("stream_log0", log_at(0), 16'hA123);
    check("stream_log1", log_at(1), 16'hB456);
    check("stream_log2", log_at(2), 16'hC789);

    // Back-pressure: two held, third waits in IF
    out_ready = 1'b0;
    log_q.delete();
    offer(16'h0010, 16'hD001);
    step();
    offer(16'h0012, 16'hD002);
    step();
    check("bp_in_ready", in_ready, 0);
    check("bp_head", out_instr, 16'hD001);
    offer(16'h0014, 16'hD003);
    step(); step();
    check("bp_hold_head", out_instr, 16'hD001);
    check("bp_hold_ready", in_ready, 0);
    out_ready = 1'b1;
    accepted = 0;
    for (int i = 0; i < 10; i++) begin
      if (in_ready) begin
        step();
        accepted = 1;
        break;
      end
      step();
    end
    check("bp_third_accepted", accepted, 1);
    in_valid = 1'b0;
    repeat (4) step();
    check("bp_log_n", log_q.size(), 3);
    check("bp_log0", log_at(0), 16'hD001);
    check("bp_log1", log_at(1), 16'hD002);
    check("bp_log2", log_at(2), 16'hD003);

    // Flush while FULL with a wrong-path word offered
    out_ready = 1'b0;
    offer(16'h0020, 16'hE001);
    step();
    offer(16'h0022, 16'hE002);
    step();
    log_q.delete();
    offer(16'h0024, 16'hDEAD);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (3) step();
    check("flush_log_empty", log_q.size(), 0);

    // Simultaneous flush and reset behaves as reset
    out_ready = 1'b0;
    offer(16'h0030, 16'h5555);
    step();
    in_valid = 1'b0;
    reset = 1'b1; flush = 1'b1;
    step();
    reset = 1'b0; flush = 1'b0;
    check("rstflush_instr", out_instr, 0);
    check("rstflush_pc4", out_pc4, 0);

    // Reset mid-operation while FULL
    offer(16'h0040, 16'hF001);
    step();
    offer(16'h0042, 16'hF002);
    step();
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst_valid", out_valid, 0);
    check("midrst_instr", out_instr, 0);
    check("midrst_pc4", out_pc4, 0);
    check("midrst_in_ready", in_ready, 1);
    log_q.delete();
    out_ready = 1'b1;
    offer(16'h0200, 16'h7001);
    step();
    in_valid = 1'b0;
    check("midrst_next_instr", out_instr, 16'h7001);
    step(); step();
    check("midrst_log_n", log_q.size(), 1);
    check("midrst_log0", log_at(0), 16'h7001);

`ifdef IF_ID_PERF_EN
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("perf_rst_stall", stall_cnt, 0);
    out_ready = 1'b0;
    offer(16'h0300, 16'h9001);
    step();
    in_valid = 1'b0;
    repeat (5) step();
    check("perf_stall5", stall_cnt, 5);
    flush = 1'b1;
    step(); step();
    flush = 1'b0;
    check("perf_flush2", flush_cnt, 2);
    repeat (3) step();
    check("perf_bubble_ge3", bubble_cnt >= 3, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    offer(16'h0302, 16'h9002);
    step();
    in_valid = 1'b0;
    repeat (65535) step();
    check("perf_stall_ffff", stall_cnt, 16'hFFFF);
    step();
    check("perf_stall_wrap", stall_cnt, 0);
    check("perf_flush_kept", flush_cnt, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_id_register.md
Name: if_id_register

Overview:
- Pipeline register between the instruction-fetch stage and the decode stage of the 16-bit processor.
- Captures each fetched instruction word and its PC+4 value, and holds them stable for decode.
- Absorbs decode back-pressure with a 2-entry skid buffer, so in_ready is a registered signal.
- Discards wrong-path instructions when a taken branch asserts flush.

Parameters:
- DATA_W, 16, width of instruction word and PC+4
- OPC_W, 4, width of opcode field (instr[15:12])

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  taken branch; kills all held and incoming instructions
- in_valid  input  1  IF presents a valid instruction
- in_ready  output  1  register can accept; registered, not combinational from out_ready
- in_pc4  input  DATA_W  PC+4 from IF
- in_instr  input  DATA_W  instruction word from instruction memory
- out_valid  output  1  decode-side entry valid
- out_ready  input  1  decode accepts entry
- out_pc4  output  DATA_W  held PC+4
- out_instr  output  DATA_W  held instruction
- out_opcode  output  OPC_W  out_instr[15:12]
- out_rs  output  4  out_instr[11:8]
- out_rt  output  4  out_instr[7:4]
- out_low  output  4  out_instr[3:0] (rd / imm4)

Behaviour:
- Reset is synchronous; clock and reset are the only timing inputs. Reset values:
  - in_ready = 1, out_valid = 0.
  - out_pc4 and out_instr = 0, so all field outputs = 0.
  - skid entry invalid.
- Field outputs are pure slices of out_instr and change only when out_instr changes.
- Storage:
  - main slot drives the outputs.
  - skid slot holds one entry when main is stalled.
  - in_ready = !skid_valid (registered).
- Transfers:
  - Input handshake: in_valid & in_ready.
  - Output handshake: out_valid & out_ready.
  - Latency is 1 cycle: an accepted input appears on the outputs on the next edge when main is empty or being drained.
- States, encoded by {skid_valid, main_valid}:
  - EMPTY (00):
    - accept -> ONE.
  - ONE (01):
    - accept with no drain -> FULL; the input goes to skid.
    - accept with drain -> ONE; the input goes to main.
    - drain without accept -> EMPTY.
  - FULL (11):
    - in_ready = 0.
    - drain -> ONE; skid moves to main.
- Ordering is strict FIFO; an entry is never duplicated or dropped except by flush or reset.
- Flush has priority over everything:
  - main_valid and skid_valid both clear on the next edge.
  - Any same-cycle input handshake is discarded.
  - in_ready = 1 next cycle.
  - Data registers may keep stale values; out_valid = 0 masks them.
- Reset asserted mid-stream is identical to flush, and additionally zeroes the data registers.
- Simultaneous flush and reset: reset result.
- While out_valid = 0 and no load occurs, out_pc4 and out_instr hold their values.

Optional Feature:
- Macro: IF_ID_PERF_EN.
- When defined, adds three outputs:
  - stall_cnt [15:0]: increments each cycle out_valid & !out_ready.
  - bubble_cnt [15:0]: increments each cycle !out_valid & !reset.
  - flush_cnt [15:0]: increments each cycle flush = 1.
- Counter rules:
  - All three wrap 16'hFFFF -> 0.
  - All three clear on reset only; flush does not clear them.
- When undefined, the ports and logic are absent and the behaviour above is unchanged.

Decomposition:
- Package if_id_pkg holds:
  - DATA_W and OPC_W.
  - Field bit positions: OPC_HI=15, RS_HI=11, RT_HI=7, LOW_HI=3.
  - NOP_INSTR = 16'h0000.
  - typedef if_id_entry_t = {pc4, instr}.
- One natural sub-module, if_id_slot: a single valid+entry register with load, clear and hold. Instantiate it twice, for main and skid.

Test Plan:
- Reset: assert reset 2 cycles with in_valid=1, in_instr=16'h1234 -> out_valid=0, out_instr=0, in_ready=1; first edge after release accepts 16'h1234.
- Streaming: out_ready=1, push pc4 0x0002/0x0004/0x0006 with instr 0xA123/0xB456/0xC789 on consecutive cycles -> same order on outputs, 1-cycle latency, no stalls; out_opcode=0xA, out_rs=1, out_rt=2, out_low=3 for the first entry.
- Back-pressure: out_ready=0 and push 3 instrs -> first two held (main, skid), in_ready=0 after the second; the third is held by IF; release out_ready -> all three emerge in order, none lost.
- Flush in FULL: fill both slots, assert flush with in_valid=1, in_instr=0xDEAD -> next cycle out_valid=0, in_ready=1; 0xDEAD never appears.
- Reset mid-operation: FULL, then reset 1 cycle -> all outputs at reset values; next entry 0x7001 appears alone.
- IF_ID_PERF_EN: 5 stall cycles, 2 flushes, 3 idle cycles -> stall_cnt=5, flush_cnt=2, bubble_cnt≥3; preload 16'hFFFF by forcing stalls -> wraps to 0.
